// File: rtl/sad_trigger_qualifier_pkg.sv
// Shared definitions for the SAD trigger qualifier: default widths and FSM state encodings.
package sad_trigger_qualifier_pkg;

  localparam int COUNT_BITS_DEFAULT = 8;
  localparam int TIMER_BITS_DEFAULT = 16;
  localparam int MISSED_BITS        = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_PULSE   = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  // PULSE and HOLDOFF form the busy sequence in which matches are ignored.
  function automatic logic is_seq_state(input logic [1:0] s);
    return (s == ST_PULSE) || (s == ST_HOLDOFF);
  endfunction

endpackage

// File: rtl/trig_dncount.sv
// Loadable down-counter that stops at zero; zero flag is high whenever the count is zero.
module trig_dncount #(
  parameter int pWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [pWIDTH-1:0] load_value,
  output logic              zero
);

  localparam logic [pWIDTH-1:0] ONE = {{(pWIDTH-1){1'b0}}, 1'b1};

  logic [pWIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                count <= '0;
    else if (load)            count <= load_value;
    else if (count != '0)     count <= count - ONE;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sad_trigger_qualifier.sv
// Qualifies raw SAD matches: N rising edges (within an optional window) produce one
// registered trigger pulse, followed by an optional holdoff during which matches are counted as missed.
module sad_trigger_qualifier
  import sad_trigger_qualifier_pkg::*;
#(
  parameter int pCOUNT_BITS = COUNT_BITS_DEFAULT,
  parameter int pTIMER_BITS = TIMER_BITS_DEFAULT
) (
  input  logic                   clk_adc,
  input  logic                   reset,
  input  logic                   armed_and_ready,
  input  logic                   sad_trigger,
  input  logic                   cfg_enable,
  input  logic [pCOUNT_BITS-1:0] cfg_match_count,
  input  logic [pTIMER_BITS-1:0] cfg_window,
  input  logic [pTIMER_BITS-1:0] cfg_pulse_width,
  input  logic [pTIMER_BITS-1:0] cfg_holdoff,
  output logic                   trigger,
  output logic [pCOUNT_BITS-1:0] match_count,
  output logic [MISSED_BITS-1:0] missed_count,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam logic [pCOUNT_BITS-1:0] C_ONE = {{(pCOUNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [pTIMER_BITS-1:0] T_ONE = {{(pTIMER_BITS-1){1'b0}}, 1'b1};
  localparam logic [MISSED_BITS-1:0] M_ONE = {{(MISSED_BITS-1){1'b0}}, 1'b1};

  logic [1:0]             state, state_nx;
  logic                   trigger_nx, busy_nx;
  logic [pCOUNT_BITS-1:0] mc_nx;
  logic [MISSED_BITS-1:0] missed_nx;
  logic                   sad_q, armed_q;
  logic                   win_armed, win_armed_nx;
  logic                   pulse_load, hold_load, win_load;
  logic                   pulse_zero, hold_zero, win_zero;
  logic [pTIMER_BITS-1:0] pulse_val, hold_val, win_val;
  logic [pCOUNT_BITS-1:0] n_eff;
  logic [pCOUNT_BITS:0]   mc_inc;
  logic                   match, reached, win_expire;
  logic [1:0]             after_seq;

  assign match      = sad_trigger & ~sad_q;
  assign n_eff      = (cfg_match_count == '0) ? C_ONE : cfg_match_count;
  assign mc_inc     = {1'b0, match_count} + {{pCOUNT_BITS{1'b0}}, 1'b1};
  assign reached    = (mc_inc >= {1'b0, n_eff});
  assign pulse_val  = (cfg_pulse_width == '0) ? '0 : cfg_pulse_width - T_ONE;
  assign hold_val   = cfg_holdoff - T_ONE;
  assign win_val    = cfg_window - T_ONE;
  // Window timer is only meaningful once a match has loaded it with a nonzero window.
  assign win_expire = win_armed && win_zero && (match_count != '0);
  assign after_seq  = armed_and_ready ? ST_WAIT : ST_IDLE;

  always_comb begin
    state_nx     = state;
    trigger_nx   = trigger;
    busy_nx      = busy;
    mc_nx        = match_count;
    win_armed_nx = win_armed;
    pulse_load   = 1'b0;
    hold_load    = 1'b0;
    win_load     = 1'b0;

    missed_nx = missed_count;
    if (armed_and_ready && !armed_q)
      missed_nx = '0;
    else if (match && is_seq_state(state) && (missed_count != '1))
      missed_nx = missed_count + M_ONE;

    if (!cfg_enable) begin
      state_nx     = ST_IDLE;
      trigger_nx   = 1'b0;
      busy_nx      = 1'b0;
      mc_nx        = '0;
      win_armed_nx = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (armed_and_ready) begin
            state_nx     = ST_WAIT;
            mc_nx        = '0;
            win_armed_nx = 1'b0;
          end
        end
        ST_WAIT: begin
          if (!armed_and_ready) begin
            state_nx     = ST_IDLE;
            mc_nx        = '0;
            win_armed_nx = 1'b0;
          end else if (match) begin
            if (reached) begin
              state_nx     = ST_PULSE;
              mc_nx        = '0;
              trigger_nx   = 1'b1;
              busy_nx      = 1'b1;
              pulse_load   = 1'b1;
              win_armed_nx = 1'b0;
            end else begin
              mc_nx        = mc_inc[pCOUNT_BITS-1:0];
              win_load     = (cfg_window != '0);
              win_armed_nx = (cfg_window != '0);
            end
          end else if (win_expire) begin
            mc_nx        = '0;
            win_armed_nx = 1'b0;
          end
        end
        ST_PULSE: begin
          if (pulse_zero) begin
            trigger_nx = 1'b0;
            if (cfg_holdoff != '0) begin
              state_nx  = ST_HOLDOFF;
              hold_load = 1'b1;
            end else begin
              state_nx = after_seq;
              busy_nx  = 1'b0;
            end
          end
        end
        ST_HOLDOFF: begin
          if (hold_zero) begin
            state_nx = after_seq;
            busy_nx  = 1'b0;
          end
        end
        default: begin
          state_nx   = ST_IDLE;
          trigger_nx = 1'b0;
          busy_nx    = 1'b0;
          mc_nx      = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_adc or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      trigger      <= 1'b0;
      busy         <= 1'b0;
      match_count  <= '0;
      missed_count <= '0;
      sad_q        <= 1'b0;
      armed_q      <= 1'b0;
      win_armed    <= 1'b0;
    end else begin
      state        <= state_nx;
      trigger      <= trigger_nx;
      busy         <= busy_nx;
      match_count  <= mc_nx;
      missed_count <= missed_nx;
      sad_q        <= sad_trigger;
      armed_q      <= armed_and_ready;
      win_armed    <= win_armed_nx;
    end
  end

  assign dbg_state = state;

  trig_dncount #(.pWIDTH(pTIMER_BITS)) u_pulse_timer (
    .clk(clk_adc), .reset(reset), .load(pulse_load), .load_value(pulse_val), .zero(pulse_zero)
  );

  trig_dncount #(.pWIDTH(pTIMER_BITS)) u_holdoff_timer (
    .clk(clk_adc), .reset(reset), .load(hold_load), .load_value(hold_val), .zero(hold_zero)
  );

  trig_dncount #(.pWIDTH(pTIMER_BITS)) u_window_timer (
    .clk(clk_adc), .reset(reset), .load(win_load), .load_value(win_val), .zero(win_zero)
  );

endmodule
